// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler_if
// Description : Bundles the signals around the writeback scheduler:
//               - writeback request bus from the execution units
//               - register-file write port
//               - issue-stage reservation and hazard query signals
//               The master modport is the environment side (execution units,
//               issue stage, register file). The slave modport is the
//               scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    // Writeback request bus, requester i occupies slice i of each vector
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    // Register-file write port
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_rd_addr;
    logic [DATA_W-1:0]         rf_rd_data;

    // Issue-stage reservation and hazard query
    logic                      issue_valid;
    logic [ADDR_W-1:0]         issue_rd;
    logic                      issue_ready;
    logic [ADDR_W-1:0]         rs1_addr;
    logic [ADDR_W-1:0]         rs2_addr;
    logic                      rs1_busy;
    logic                      rs2_busy;
    logic                      wb_spurious;

    modport master (
        output req_valid, req_rd, req_data,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  req_ready,
        input  rf_we, rf_rd_addr, rf_rd_data,
        input  issue_ready, rs1_busy, rs2_busy, wb_spurious
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output req_ready,
        output rf_we, rf_rd_addr, rf_rd_data,
        output issue_ready, rs1_busy, rs2_busy, wb_spurious
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Shares the single register-file write port among NUM_REQ
//               writeback sources (0 = ALU, 1 = LSU, 2 = NPU).
//               - Registers exactly one write per cycle, with a latency of 1.
//               - Keeps a per-register busy scoreboard so the issue stage can
//                 detect RAW hazards (through rs1_busy / rs2_busy) and WAW
//                 hazards (through issue_ready).
//               - Register 0 is hardwired zero. It is never written and is
//                 never busy.
//               Optional feature macro: WB_ROUND_ROBIN_EN
//                 defined   : round-robin arbitration with a rotating pointer
//                 undefined : fixed priority, where the lowest index wins
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  wire                    clk,
    input  wire                    rst_n,
    regfile_wb_scheduler_if.slave  wb_if
);

    localparam int C_NREGS = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] grant_w;
    logic               hs_w;
    logic [ADDR_W-1:0]  sel_rd_w;
    logic [DATA_W-1:0]  sel_data_w;

`ifdef WB_ROUND_ROBIN_EN
    localparam int C_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [C_PTR_W-1:0] ptr_q;
    logic [C_PTR_W-1:0] ptr_d;
    int                 cand_w;
    logic               found_w;

    // Round-robin grant: scan from the pointer index, wrapping modulo NUM_REQ
    always_comb begin
        grant_w = '0;
        found_w = 1'b0;
        cand_w  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_w = int'(ptr_q) + k;
            if (cand_w >= NUM_REQ) begin
                cand_w = cand_w - NUM_REQ;
            end
            if (!found_w && wb_if.req_valid[cand_w]) begin
                grant_w[cand_w] = 1'b1;
                found_w         = 1'b1;
            end
        end
    end

    // Next pointer: one past the granted requester; hold on idle cycles
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_w[i]) begin
                ptr_d = (i == NUM_REQ - 1) ? '0 : C_PTR_W'(i + 1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority grant: scan downwards so the lowest valid index wins
    always_comb begin
        grant_w = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (wb_if.req_valid[i]) begin
                grant_w    = '0;
                grant_w[i] = 1'b1;
            end
        end
    end
`endif

    assign hs_w            = |grant_w;
    assign wb_if.req_ready = grant_w;

    // Select the destination and data of the granted requester
    always_comb begin
        sel_rd_w   = '0;
        sel_data_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_w[i]) begin
                sel_rd_w   = wb_if.req_rd[i*ADDR_W +: ADDR_W];
                sel_data_w = wb_if.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_data_q;
    logic              wr_w;

    // A handshake to register 0 is accepted but produces no write
    assign wr_w = hs_w && (sel_rd_w != '0);

    // Write-port pipeline register; address and data hold while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q <= wr_w;
            if (wr_w) begin
                rf_addr_q <= sel_rd_w;
                rf_data_q <= sel_data_w;
            end
        end
    end

    assign wb_if.rf_we      = rf_we_q;
    assign wb_if.rf_rd_addr = rf_addr_q;
    assign wb_if.rf_rd_data = rf_data_q;

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    logic [C_NREGS-1:0] busy_q;
    logic [C_NREGS-1:0] busy_d;
    logic               issue_rdy_w;
    logic               set_w;

    // WAW stall: a reservation waits until the previous write has committed
    assign issue_rdy_w = ~busy_q[wb_if.issue_rd];
    assign set_w       = wb_if.issue_valid && issue_rdy_w && (wb_if.issue_rd != '0);

    // Clear on the commit edge, then set on reservation; register 0 never busy
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_addr_q] = 1'b0;
        end
        if (set_w) begin
            busy_d[wb_if.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign wb_if.issue_ready = issue_rdy_w;

    // No bypass: a register that is being written this cycle still reports busy
    assign wb_if.rs1_busy    = busy_q[wb_if.rs1_addr];
    assign wb_if.rs2_busy    = busy_q[wb_if.rs2_addr];

    // A committed write that has no reservation is flagged for the cycle it is on the port
    assign wb_if.wb_spurious = rf_we_q && !busy_q[rf_addr_q] && (rf_addr_q != '0);

endmodule
`default_nettype wire
